// File: rtl/seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_pkg : reset-default pattern/length and length-field width helper |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package seq_pkg;

    localparam int         DEF_LEN = 3;
    localparam logic [2:0] DEF_PAT = 3'b111;

    function automatic int len_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_detector_param : programmable serial pattern detector with       |
// | overlap control and saturating match counter.  Rev 1.0               |
// +----------------------------------------------------------------------+
module seq_detector_param
    import seq_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        X,
    input  logic                        en,
    input  logic                        cfg_load,
    input  logic [PAT_W-1:0]            pat,
    input  logic [len_width(PAT_W)-1:0] pat_len,
    input  logic                        overlap,
    input  logic                        cnt_clr,
    output logic                        Y,
    output logic [CNT_W-1:0]            match_cnt,
    output logic                        cnt_sat
);

    localparam int             LEN_W     = len_width(PAT_W);
    localparam logic [LEN_W-1:0] C_FULL  = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] C_RST_LEN =
        (DEF_LEN > PAT_W) ? LEN_W'(PAT_W) : LEN_W'(DEF_LEN);

    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;
    logic             y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    logic [PAT_W-1:0] w_hist_sh;
    logic [LEN_W-1:0] w_fill_inc;
    logic [PAT_W-1:0] w_mask;
    logic             w_hit;
    logic [LEN_W-1:0] w_len_clamp;

    always_comb begin
        w_hist_sh  = {hist_q[PAT_W-2:0], X};
        w_fill_inc = (fill_q == C_FULL) ? fill_q : fill_q + LEN_W'(1);
        // Shifting by PAT_W yields zero, so a full-length pattern gets an all-ones mask.
        w_mask     = ~({PAT_W{1'b1}} << len_q);
        w_hit      = (w_fill_inc >= len_q) &&
                     ((w_hist_sh & w_mask) == (pat_q & w_mask));
        w_len_clamp = pat_len;
        if (pat_len == '0) begin
            w_len_clamp = LEN_W'(1);
        end else if (pat_len > C_FULL) begin
            w_len_clamp = C_FULL;
        end
    end

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        y_d    = 1'b0;
        if (cfg_load) begin
            pat_d  = pat;
            len_d  = w_len_clamp;
            ovl_d  = overlap;
            fill_d = '0;
        end else if (en) begin
            hist_d = w_hist_sh;
            fill_d = (w_hit && !ovl_q) ? '0 : w_fill_inc;
            y_d    = w_hit;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (cnt_clr) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (y_d) begin
            if (cnt_q == '1) begin
                sat_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= PAT_W'(DEF_PAT);
            len_q  <= C_RST_LEN;
            ovl_q  <= 1'b1;
            y_q    <= 1'b0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            y_q    <= y_d;
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
        end
    end

    assign Y         = y_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seq_detector_param : table-driven bench for seq_detector_param    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_seq_detector_param;

    localparam int PAT_W = 8;
    localparam int CNT_W = 2;

    typedef struct {
        logic       rst_n;
        logic       cfg;
        logic       en;
        logic       x;
        logic       clr;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ov;
        logic       exp_y;
        logic [1:0] exp_cnt;
        logic       exp_sat;
        logic       chk_cnt;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             X;
    logic             en;
    logic             cfg_load;
    logic [PAT_W-1:0] pat;
    logic [3:0]       pat_len;
    logic             overlap;
    logic             cnt_clr;
    logic             Y;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    int n_checks = 0;
    int n_errors = 0;

    seq_detector_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .X(X), .en(en), .cfg_load(cfg_load),
        .pat(pat), .pat_len(pat_len), .overlap(overlap), .cnt_clr(cnt_clr),
        .Y(Y), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic c, logic e, logic x, logic cl,
                                logic [7:0] p, logic [3:0] l, logic o,
                                logic ey, logic [1:0] ec, logic es);
        vec_t v;
        v.rst_n = r;  v.cfg = c; v.en = e; v.x = x; v.clr = cl;
        v.pat = p;    v.len = l; v.ov = o;
        v.exp_y = ey; v.exp_cnt = ec; v.exp_sat = es; v.chk_cnt = 1'b1;
        return v;
    endfunction

    // Bit-only step for the hand sequences: count state is not checked.
    function automatic vec_t bit_(logic e, logic x, logic ey);
        vec_t v;
        v = mk(1'b1, 1'b0, e, x, 1'b0, 8'h00, 4'd0, 1'b0, ey, 2'd0, 1'b0);
        v.chk_cnt = 1'b0;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag, input int idx);
        @(negedge clk);
        rst = v.rst_n; cfg_load = v.cfg; en = v.en; X = v.x; cnt_clr = v.clr;
        pat = v.pat; pat_len = v.len; overlap = v.ov;
        @(posedge clk);
        #1;
        n_checks++;
        if (Y !== v.exp_y) begin
            n_errors++;
            $display("FAIL %s[%0d] Y: got %b expected %b", tag, idx, Y, v.exp_y);
        end
        if (v.chk_cnt) begin
            n_checks += 2;
            if (match_cnt !== v.exp_cnt) begin
                n_errors++;
                $display("FAIL %s[%0d] match_cnt: got %0d expected %0d",
                         tag, idx, match_cnt, v.exp_cnt);
            end
            if (cnt_sat !== v.exp_sat) begin
                n_errors++;
                $display("FAIL %s[%0d] cnt_sat: got %b expected %b",
                         tag, idx, cnt_sat, v.exp_sat);
            end
        end
    endtask

    vec_t tbl[$];
    vec_t hs[$];

    initial begin
        rst = 1'b0; X = 1'b0; en = 1'b0; cfg_load = 1'b0; pat = '0;
        pat_len = '0; overlap = 1'b0; cnt_clr = 1'b0;

        // reset
        tbl.push_back(mk(0,0,0,0,0, 8'h00,4'd0,0, 0,2'd0,0));
        tbl.push_back(mk(0,0,1,1,0, 8'h00,4'd0,0, 0,2'd0,0));
        // reset default 111: X=1 for 5 bits, then a saturating 4th count, then clear
        tbl.push_back(mk(1,0,1,1,0, 8'h00,4'd0,0, 0,2'd0,0));
        tbl.push_back(mk(1,0,1,1,0, 8'h00,4'd0,0, 0,2'd0,0));
        tbl.push_back(mk(1,0,1,1,0, 8'h00,4'd0,0, 1,2'd1,0));
        tbl.push_back(mk(1,0,1,1,0, 8'h00,4'd0,0, 1,2'd2,0));
        tbl.push_back(mk(1,0,1,1,0, 8'h00,4'd0,0, 1,2'd3,0));
        tbl.push_back(mk(1,0,1,1,0, 8'h00,4'd0,0, 1,2'd3,1));
        tbl.push_back(mk(1,0,0,0,1, 8'h00,4'd0,0, 0,2'd0,0));
        // 1011 overlapping over 1,0,1,1,0,1,1
        tbl.push_back(mk(1,1,0,0,0, 8'h0B,4'd4,1, 0,2'd0,0));
        tbl.push_back(mk(1,0,1,1,0, 8'h00,4'd0,0, 0,2'd0,0));
        tbl.push_back(mk(1,0,1,0,0, 8'h00,4'd0,0, 0,2'd0,0));
        tbl.push_back(mk(1,0,1,1,0, 8'h00,4'd0,0, 0,2'd0,0));
        tbl.push_back(mk(1,0,1,1,0, 8'h00,4'd0,0, 1,2'd1,0));
        tbl.push_back(mk(1,0,1,0,0, 8'h00,4'd0,0, 0,2'd1,0));
        tbl.push_back(mk(1,0,1,1,0, 8'h00,4'd0,0, 0,2'd1,0));
        tbl.push_back(mk(1,0,1,1,0, 8'h00,4'd0,0, 1,2'd2,0));
        tbl.push_back(mk(1,0,0,0,1, 8'h00,4'd0,0, 0,2'd0,0));
        // same stream non-overlapping
        tbl.push_back(mk(1,1,0,0,0, 8'h0B,4'd4,0, 0,2'd0,0));
        tbl.push_back(mk(1,0,1,1,0, 8'h00,4'd0,0, 0,2'd0,0));
        tbl.push_back(mk(1,0,1,0,0, 8'h00,4'd0,0, 0,2'd0,0));
        tbl.push_back(mk(1,0,1,1,0, 8'h00,4'd0,0, 0,2'd0,0));
        tbl.push_back(mk(1,0,1,1,0, 8'h00,4'd0,0, 1,2'd1,0));
        tbl.push_back(mk(1,0,1,0,0, 8'h00,4'd0,0, 0,2'd1,0));
        tbl.push_back(mk(1,0,1,1,0, 8'h00,4'd0,0, 0,2'd1,0));
        tbl.push_back(mk(1,0,1,1,0, 8'h00,4'd0,0, 0,2'd1,0));
        tbl.push_back(mk(1,0,0,0,1, 8'h00,4'd0,0, 0,2'd0,0));
        // pattern 1 len 1: saturation at CNT_W=2, clear, clear-vs-increment
        tbl.push_back(mk(1,1,0,0,0, 8'h01,4'd1,1, 0,2'd0,0));
        tbl.push_back(mk(1,0,1,1,0, 8'h00,4'd0,0, 1,2'd1,0));
        tbl.push_back(mk(1,0,1,1,0, 8'h00,4'd0,0, 1,2'd2,0));
        tbl.push_back(mk(1,0,1,1,0, 8'h00,4'd0,0, 1,2'd3,0));
        tbl.push_back(mk(1,0,1,1,0, 8'h00,4'd0,0, 1,2'd3,1));
        tbl.push_back(mk(1,0,1,1,0, 8'h00,4'd0,0, 1,2'd3,1));
        tbl.push_back(mk(1,0,0,0,1, 8'h00,4'd0,0, 0,2'd0,0));
        tbl.push_back(mk(1,0,1,1,1, 8'h00,4'd0,0, 1,2'd0,0));
        tbl.push_back(mk(1,0,1,0,0, 8'h00,4'd0,0, 0,2'd0,0));
        tbl.push_back(mk(1,0,1,1,0, 8'h00,4'd0,0, 1,2'd1,0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], "tbl", i);

        // reset mid-pattern: 1,1, reset, then 1,1,1 -> Y only on the last
        hs.delete();
        hs.push_back(mk(1,1,0,0,0, 8'h07,4'd3,1, 0,2'd1,0));
        hs[0].chk_cnt = 1'b0;
        hs.push_back(bit_(1,1,0));
        hs.push_back(bit_(1,1,0));
        hs.push_back(mk(0,0,1,1,0, 8'h00,4'd0,0, 0,2'd0,0));
        hs.push_back(bit_(1,1,0));
        hs.push_back(bit_(1,1,0));
        hs.push_back(bit_(1,1,1));
        for (int i = 0; i < hs.size(); i++) apply(hs[i], "rst_mid", i);

        // en gaps: X held at 1 while en toggles 1,0,1,0,1
        hs.delete();
        hs.push_back(mk(1,1,0,1,0, 8'h07,4'd3,1, 0,2'd0,0));
        hs[0].chk_cnt = 1'b0;
        hs.push_back(bit_(1,1,0));
        hs.push_back(bit_(0,1,0));
        hs.push_back(bit_(1,1,0));
        hs.push_back(bit_(0,1,0));
        hs.push_back(bit_(1,1,1));
        hs.push_back(bit_(0,1,0));
        for (int i = 0; i < hs.size(); i++) apply(hs[i], "en_gap", i);

        // pat_len=0 latches as 1; cfg_load with en=1 suppresses Y
        hs.delete();
        hs.push_back(mk(1,1,1,1,0, 8'h01,4'd0,1, 0,2'd0,0));
        hs[0].chk_cnt = 1'b0;
        hs.push_back(bit_(1,1,1));
        hs.push_back(bit_(1,0,0));
        hs.push_back(bit_(1,1,1));
        for (int i = 0; i < hs.size(); i++) apply(hs[i], "len0", i);

        // pat_len above PAT_W clamps to 8: A5 sent MSB first
        hs.delete();
        hs.push_back(mk(1,1,0,0,0, 8'hA5,4'd15,1, 0,2'd0,0));
        hs[0].chk_cnt = 1'b0;
        for (int b = 7; b >= 0; b--) begin
            logic [7:0] p;
            p = 8'hA5;
            hs.push_back(bit_(1, p[b], (b == 0) ? 1'b1 : 1'b0));
        end
        for (int i = 0; i < hs.size(); i++) apply(hs[i], "len_hi", i);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
